// File: rtl/mem_rd_burst_responder_if.sv
// Read-burst bus bundle: line request, beat response and the SRAM port.
// The responder uses the slave modport; the cache/bench side uses master.
interface mem_rd_burst_responder_if #(
   parameter int SRAM_AW = 12
);
   logic               rd_req_valid;
   logic [31:0]        rd_req_addr;
   logic               rd_req_ready;
   logic               rd_rsp_valid;
   logic [31:0]        rd_rsp_data;
   logic               rd_rsp_last;
   logic               rd_rsp_ready;
   logic               sram_ren;
   logic [SRAM_AW-1:0] sram_raddr;
   logic [31:0]        sram_rdata;

   modport slave (
      input  rd_req_valid, rd_req_addr, rd_rsp_ready, sram_rdata,
      output rd_req_ready, rd_rsp_valid, rd_rsp_data, rd_rsp_last, sram_ren, sram_raddr
   );

   modport master (
      output rd_req_valid, rd_req_addr, rd_rsp_ready, sram_rdata,
      input  rd_req_ready, rd_rsp_valid, rd_rsp_data, rd_rsp_last, sram_ren, sram_raddr
   );
endinterface

// File: rtl/mem_rd_burst_responder.sv
// Line read-burst responder: fetches BURST_LEN words from a sync-read SRAM and streams them out.
// Define MEM_RSP_DELAY_EN to insert a RSP_DELAY-cycle WAIT state between accept and the first read.
module mem_rd_burst_responder #(
   parameter int BURST_LEN = 8,
   parameter int SRAM_AW   = 12,
   parameter int RSP_DELAY = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   mem_rd_burst_responder_if.slave  bus
);
   localparam int CW = $clog2(BURST_LEN) + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1
`ifdef MEM_RSP_DELAY_EN
      , S_WAIT = 2'd2
`endif
   } state_t;

   state_t             r_state;
   state_t             w_state_next;
   logic [SRAM_AW-1:0] r_base;
   logic [CW-1:0]      r_issued_cnt;
   logic [CW-1:0]      r_beat_cnt;
   logic               r_inflight;
   logic [1:0]         r_count;
   logic               r_wr_ptr;
   logic               r_rd_ptr;
   logic [31:0]        r_fifo [0:1];

   logic               w_req_ready;
   logic               w_ren;
   logic               w_accept;
   logic               w_valid;
   logic [31:0]        w_head;
   logic               w_pop;
   logic               w_push;
   logic               w_fifo_pop;
   logic               w_last;
   logic [SRAM_AW-1:0] w_req_base;
   logic               w_unused;

   assign w_accept   = bus.rd_req_valid && w_req_ready;
   assign w_req_base = bus.rd_req_addr[SRAM_AW+1:2] & ~SRAM_AW'(BURST_LEN - 1);
   assign w_unused   = &{1'b0, bus.rd_req_addr[31:SRAM_AW+2], bus.rd_req_addr[1:0], RSP_DELAY[0]};

   // The word returning from the SRAM this cycle is presented directly when the
   // buffer is empty, so the first beat appears one cycle after its read.
   assign w_valid    = (r_count != 2'd0) || r_inflight;
   assign w_head     = (r_count != 2'd0) ? r_fifo[r_rd_ptr] : bus.sram_rdata;
   assign w_pop      = w_valid && bus.rd_rsp_ready;
   assign w_push     = r_inflight && !((r_count == 2'd0) && w_pop);
   assign w_fifo_pop = w_pop && (r_count != 2'd0);
   assign w_last     = w_valid && (r_beat_cnt == CW'(BURST_LEN - 1));

   assign bus.rd_req_ready = w_req_ready;
   assign bus.rd_rsp_valid = w_valid;
   assign bus.rd_rsp_data  = w_valid ? w_head : 32'd0;
   assign bus.rd_rsp_last  = w_last;
   assign bus.sram_ren     = w_ren;
   assign bus.sram_raddr   = r_base + SRAM_AW'(r_issued_cnt);

`ifdef MEM_RSP_DELAY_EN
   logic [3:0] r_delay_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_delay_cnt <= 4'd0;
      end else if (w_accept) begin
         r_delay_cnt <= 4'(RSP_DELAY);
      end else if ((r_state == S_WAIT) && (r_delay_cnt != 4'd0)) begin
         r_delay_cnt <= r_delay_cnt - 4'd1;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
`ifdef MEM_RSP_DELAY_EN
               w_state_next = S_WAIT;
`else
               w_state_next = S_FETCH;
`endif
            end
         end
`ifdef MEM_RSP_DELAY_EN
         // Leave on the cycle the counter steps to zero so FETCH starts right after.
         S_WAIT: begin
            if (r_delay_cnt <= 4'd1) begin
               w_state_next = S_FETCH;
            end
         end
`endif
         S_FETCH: begin
            if (w_pop && w_last) begin
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Reads are throttled so buffered plus in-flight words never exceed two.
   always_comb begin
      w_req_ready = 1'b0;
      w_ren       = 1'b0;
      case (r_state)
         S_IDLE:  w_req_ready = 1'b1;
         S_FETCH: w_ren = (r_issued_cnt < CW'(BURST_LEN)) &&
                          ((r_count + {1'b0, r_inflight}) < 2'd2);
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_base       <= '0;
         r_issued_cnt <= '0;
         r_beat_cnt   <= '0;
         r_inflight   <= 1'b0;
         r_count      <= 2'd0;
         r_wr_ptr     <= 1'b0;
         r_rd_ptr     <= 1'b0;
      end else begin
         if (w_accept) begin
            r_base       <= w_req_base;
            r_issued_cnt <= '0;
            r_beat_cnt   <= '0;
         end else begin
            if (w_ren) begin
               r_issued_cnt <= r_issued_cnt + CW'(1);
            end
            if (w_pop) begin
               r_beat_cnt <= r_beat_cnt + CW'(1);
            end
         end
         r_inflight <= w_ren;
         if (w_push) begin
            r_wr_ptr <= ~r_wr_ptr;
         end
         if (w_fifo_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         r_count <= r_count + 2'(w_push) - 2'(w_fifo_pop);
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_fifo
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               r_fifo[gi] <= 32'd0;
            end else if (w_push && (int'(r_wr_ptr) == gi)) begin
               r_fifo[gi] <= bus.sram_rdata;
            end
         end
      end
   endgenerate
endmodule

// File: tb/tb_mem_rd_burst_responder.sv
// Directed bench for mem_rd_burst_responder: table of burst requests with ready patterns,
// plus hand-written reset sequences. SRAM model holds 0xA000_0000 + word address.
module tb_mem_rd_burst_responder;
   localparam int BL = 8;
   localparam int AW = 12;
`ifdef MEM_RSP_DELAY_EN
   localparam int DLY = 4;
`else
   localparam int DLY = 0;
`endif

   typedef struct {
      string       name;
      logic [31:0] addr;
      logic [15:0] pat;
      logic [11:0] exp_base;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   mem_rd_burst_responder_if #(.SRAM_AW(AW)) bus ();

   mem_rd_burst_responder #(
      .BURST_LEN (BL),
      .SRAM_AW   (AW),
      .RSP_DELAY (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [31:0] mem [0:4095];

   always @(posedge clk) begin
      if (bus.sram_ren) begin
         bus.sram_rdata <= mem[bus.sram_raddr];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, 32'(bus.rd_req_ready), 32'd1);
      chk({tag, "_rsp_valid"}, 32'(bus.rd_rsp_valid), 32'd0);
      chk({tag, "_rsp_data"},  bus.rd_rsp_data,        32'd0);
      chk({tag, "_rsp_last"},  32'(bus.rd_rsp_last),  32'd0);
      chk({tag, "_sram_ren"},  32'(bus.sram_ren),     32'd0);
      chk({tag, "_sram_raddr"}, 32'(bus.sram_raddr),  32'd0);
   endtask

   task automatic run_burst(input vec_t v);
      int          nbeat;
      int          nren;
      int          first_ren;
      int          first_val;
      int          last_cyc;
      int          max_out;
      logic        req_seen;
      logic        stalled;
      logic        done;
      logic [31:0] held_data;
      logic        held_last;
      logic [11:0] e_addr;
      nbeat = 0; nren = 0; first_ren = -1; first_val = -1; last_cyc = -1; max_out = 0;
      req_seen = 1'b0; stalled = 1'b0; done = 1'b0; held_data = '0; held_last = 1'b0;

      @(negedge clk);
      chk({v.name, "_req_ready_idle"}, 32'(bus.rd_req_ready), 32'd1);
      bus.rd_req_valid = 1'b1;
      bus.rd_req_addr  = v.addr;
      @(posedge clk);
      #1;
      bus.rd_req_valid = 1'b0;
      for (int cyc = 1; cyc <= 200 && !done; cyc++) begin
         bus.rd_rsp_ready = v.pat[(cyc - 1) % 16];
         @(negedge clk);
         if (last_cyc >= 0) begin
            chk({v.name, "_req_ready_after"}, 32'(bus.rd_req_ready), 32'd1);
            chk({v.name, "_valid_after"},     32'(bus.rd_rsp_valid), 32'd0);
            done = 1'b1;
         end else begin
            if (bus.rd_req_ready) req_seen = 1'b1;
            if (stalled) begin
               chk({v.name, "_stall_valid"}, 32'(bus.rd_rsp_valid), 32'd1);
               chk({v.name, "_stall_data"},  bus.rd_rsp_data,        held_data);
               chk({v.name, "_stall_last"},  32'(bus.rd_rsp_last),  32'(held_last));
            end
            if (bus.sram_ren) begin
               if (first_ren < 0) first_ren = cyc;
               e_addr = v.exp_base + 12'(nren);
               chk({v.name, "_raddr"}, 32'(bus.sram_raddr), 32'(e_addr));
               nren++;
            end
            if (nren - nbeat > max_out) max_out = nren - nbeat;
            if (bus.rd_rsp_valid && first_val < 0) first_val = cyc;
            stalled   = bus.rd_rsp_valid && !bus.rd_rsp_ready;
            held_data = bus.rd_rsp_data;
            held_last = bus.rd_rsp_last;
            if (bus.rd_rsp_valid && bus.rd_rsp_ready) begin
               e_addr = v.exp_base + 12'(nbeat);
               chk({v.name, "_data"}, bus.rd_rsp_data, 32'hA000_0000 + 32'(e_addr));
               chk({v.name, "_last"}, 32'(bus.rd_rsp_last), 32'(nbeat == BL - 1));
               nbeat++;
               if (nbeat == BL) last_cyc = cyc;
            end
         end
         if (!done) begin
            @(posedge clk);
            #1;
         end
      end
      chk({v.name, "_finished_in_budget"}, 32'(done), 32'd1);
      chk({v.name, "_beats"}, 32'(nbeat), 32'(BL));
      chk({v.name, "_reads"}, 32'(nren), 32'(BL));
      chk({v.name, "_outstanding_le2"}, 32'(max_out <= 2), 32'd1);
      chk({v.name, "_req_ready_low_in_burst"}, 32'(req_seen), 32'd0);
      if (v.pat == 16'hFFFF) begin
         chk({v.name, "_first_ren_cyc"},  32'(first_ren), 32'(1 + DLY));
         chk({v.name, "_first_valid_cyc"}, 32'(first_val), 32'(2 + DLY));
         chk({v.name, "_last_beat_cyc"},  32'(last_cyc),  32'(1 + DLY + BL));
      end
      $display("burst %s addr=0x%08h pat=0x%04h beats=%0d reads=%0d first_ren=%0d first_valid=%0d last_cyc=%0d max_out=%0d",
               v.name, v.addr, v.pat, nbeat, nren, first_ren, first_val, last_cyc, max_out);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [6];
      vec_t after_rst;
      int   hs;

      vecs[0] = '{"aligned_0x40",    32'h0000_0040, 16'hFFFF, 12'h010};
      vecs[1] = '{"unaligned_0x5C",  32'h0000_005C, 16'hFFFF, 12'h010};
      vecs[2] = '{"toggle_ready",    32'h0000_0040, 16'h9A69, 12'h010};
      vecs[3] = '{"top_0x3FE0",      32'h0000_3FE0, 16'hFFFF, 12'hFF8};
      vecs[4] = '{"wrap_0x4000",     32'h0000_4000, 16'hFFFF, 12'h000};
      vecs[5] = '{"mixed_ready_120", 32'h0000_0120, 16'h5A3C, 12'h048};
      after_rst = '{"after_rst_0x80", 32'h0000_0080, 16'hFFFF, 12'h020};

      for (int i = 0; i < 4096; i++) mem[i] = 32'hA000_0000 + 32'(i);
      bus.rd_req_valid = 1'b0;
      bus.rd_req_addr  = 32'd0;
      bus.rd_rsp_ready = 1'b0;

      // Power-on reset, checked before the first clock edge and again after a few clocks.
      #1 rst = 1'b0;
      #2;
      chk_reset_outputs("por_async");
      repeat (3) @(negedge clk);
      chk_reset_outputs("por_held");
      rst = 1'b1;

      for (int i = 0; i < 6; i++) run_burst(vecs[i]);

      // Reset in the middle of a burst, just after the third beat has been accepted.
      @(negedge clk);
      bus.rd_req_valid = 1'b1;
      bus.rd_req_addr  = 32'h0000_0040;
      @(posedge clk);
      #1;
      bus.rd_req_valid = 1'b0;
      bus.rd_rsp_ready = 1'b1;
      hs = 0;
      for (int cyc = 0; cyc < 40 && hs < 3; cyc++) begin
         @(negedge clk);
         if (bus.rd_rsp_valid && bus.rd_rsp_ready) hs++;
      end
      chk("midrst_three_beats_seen", 32'(hs), 32'd3);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk_reset_outputs("midrst_async");
      for (int cyc = 0; cyc < 3; cyc++) begin
         @(negedge clk);
         chk("midrst_no_beat", 32'(bus.rd_rsp_valid), 32'd0);
         chk("midrst_no_read", 32'(bus.sram_ren), 32'd0);
      end
      rst = 1'b1;
      $display("reset asserted mid-burst after %0d beats", hs);

      run_burst(after_rst);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
